// File: rtl/approx_rc_adder_pipe_pkg.sv
// Shared cell-type encoding and the single-bit approximate adder cell function
// used by the segmented ripple-carry pipeline.
package approx_adder_pkg;

  typedef enum logic [1:0] {
    CT_CONST = 2'd0,
    CT_TRUNC = 2'd1,
    CT_OR    = 2'd2,
    CT_EXACT = 2'd3
  } cell_type_e;

  // Returns {cout, s}; approximate behaviour applies only when approx_en is set.
  function automatic logic [1:0] cell_fn(input logic x, input logic y, input logic z,
                                         input cell_type_e t, input logic approx_en);
    logic [1:0] r;
    r = {(x & y) | (z & (x ^ y)), x ^ y ^ z};
    if (approx_en) begin
      case (t)
        CT_CONST: r = 2'b10;
        CT_TRUNC: r = 2'b00;
        CT_OR:    r = {x & y, x | y};
        default:  ;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/approx_rc_adder_pipe_if.sv
// Operand/result valid-ready bundle for the approximate adder pipeline.
interface approx_rc_adder_pipe_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned APPROX_MAX = 8
);
  localparam int unsigned KW = $clog2(APPROX_MAX + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_a;
  logic [WIDTH-1:0]        in_b;
  logic [KW-1:0]           in_k;
  logic [1:0]              in_type;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH:0]          out_sum;
  logic signed [WIDTH+1:0] out_err;

  modport master (
    output in_valid, in_a, in_b, in_k, in_type, out_ready,
    input  in_ready, out_valid, out_sum, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_k, in_type, out_ready,
    output in_ready, out_valid, out_sum, out_err
  );

endinterface

// File: rtl/approx_rc_adder_pipe_cell.sv
// One bit of the adder: exact full adder, or an approximate cell when enabled.
module approx_cell
  import approx_adder_pkg::*;
(
  input  logic       x_i,
  input  logic       y_i,
  input  logic       z_i,
  input  cell_type_e type_i,
  input  logic       approx_en_i,
  output logic       s_o,
  output logic       cout_o
);

  assign {cout_o, s_o} = cell_fn(x_i, y_i, z_i, type_i, approx_en_i);

endmodule

// File: rtl/approx_rc_adder_pipe.sv
// Segmented ripple-carry approximate adder: one segment per pipeline rank, global
// stall on output backpressure, error and squared-error statistics on the output side.
module approx_rc_adder_pipe
  import approx_adder_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SEG_W      = 4,
  parameter int unsigned APPROX_MAX = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  approx_rc_adder_pipe_if.slave         bus,
  input  logic                          stat_clr,
  output logic [CNT_W-1:0]              stat_cnt,
  output logic [2*(WIDTH+2)+CNT_W-1:0]  stat_sqerr
);

  localparam int unsigned NSEG = (WIDTH + SEG_W - 1) / SEG_W;
  localparam int unsigned KW   = $clog2(APPROX_MAX + 1);
  localparam int unsigned EW   = WIDTH + 2;
  localparam int unsigned SQW  = 2 * EW;
  localparam int unsigned SW   = SQW + CNT_W;
  localparam int unsigned LAST = NSEG - 1;
  localparam logic [KW-1:0] KMAX = KW'(APPROX_MAX);

  function automatic logic [WIDTH-1:0] seg_mask(input int unsigned s);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i / SEG_W == s) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Rank s holds a sample whose segments 0..s-1 are already resolved in sm_q[s].
  logic [NSEG-1:0]            vld_q, vld_d, cy_q, cy_d;
  logic [NSEG-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, sm_q, sm_d;
  logic [NSEG-1:0][KW-1:0]    k_q, k_d;
  logic [NSEG-1:0][1:0]       ty_q, ty_d;

  logic                 ov_q;
  logic [WIDTH:0]       osum_q, osum_d;
  logic signed [EW-1:0] oerr_q, oerr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]        sq_q, sq_d;

  logic [WIDTH-1:0] s_w, fin_w;
  logic [NSEG-1:0]  segc_w;
  logic [WIDTH:0]   exact_w;
  logic [EW-1:0]    err_u, mag;
  logic [SQW-1:0]   sq;
  logic [SW:0]      sq_sum;
  logic             en, xfer_out;

  assign en            = !ov_q || bus.out_ready;
  assign xfer_out      = ov_q && bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = ov_q;
  assign bus.out_sum   = osum_q;
  assign bus.out_err   = oerr_q;
  assign stat_cnt      = cnt_q;
  assign stat_sqerr    = sq_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    localparam int unsigned S = gi / SEG_W;
    logic cin, aen, so, co;
    if (gi % SEG_W == 0) begin : g_seg_lsb
      assign cin = cy_q[S];
    end else begin : g_ripple
      assign cin = g_bit[gi-1].co;
    end
    if ((gi % SEG_W == SEG_W - 1) || (gi == WIDTH - 1)) begin : g_seg_msb
      assign segc_w[S] = co;
    end
    assign aen     = (32'(k_q[S]) > 32'(gi));
    assign s_w[gi] = so;
    approx_cell u_cell (
      .x_i        (a_q[S][gi]),
      .y_i        (b_q[S][gi]),
      .z_i        (cin),
      .type_i     (cell_type_e'(ty_q[S])),
      .approx_en_i(aen),
      .s_o        (so),
      .cout_o     (co)
    );
  end

  always_comb begin
    vld_d = '0;
    cy_d  = '0;
    a_d   = '0;
    b_d   = '0;
    sm_d  = '0;
    k_d   = '0;
    ty_d  = '0;
    vld_d[0] = bus.in_valid;
    a_d[0]   = bus.in_a;
    b_d[0]   = bus.in_b;
    k_d[0]   = (bus.in_k > KMAX) ? KMAX : bus.in_k;
    ty_d[0]  = bus.in_type;
    for (int unsigned s = 1; s < NSEG; s++) begin
      vld_d[s] = vld_q[s-1];
      a_d[s]   = a_q[s-1];
      b_d[s]   = b_q[s-1];
      k_d[s]   = k_q[s-1];
      ty_d[s]  = ty_q[s-1];
      cy_d[s]  = segc_w[s-1];
      sm_d[s]  = (sm_q[s-1] & ~seg_mask(s-1)) | (s_w & seg_mask(s-1));
    end
    fin_w   = (sm_q[LAST] & ~seg_mask(LAST)) | (s_w & seg_mask(LAST));
    osum_d  = {segc_w[LAST], fin_w};
    exact_w = {1'b0, a_q[LAST]} + {1'b0, b_q[LAST]};
    oerr_d  = $signed({1'b0, exact_w}) - $signed({1'b0, osum_d});
  end

  // Clear coincident with a transfer restarts the stats from that sample alone.
  always_comb begin
    err_u  = oerr_q;
    mag    = err_u[EW-1] ? (~err_u + EW'(1)) : err_u;
    sq     = SQW'(mag) * SQW'(mag);
    sq_sum = {1'b0, sq_q} + (SW+1)'(sq);
    cnt_d  = cnt_q;
    sq_d   = sq_q;
    if (stat_clr) begin
      cnt_d = xfer_out ? CNT_W'(1) : '0;
      sq_d  = xfer_out ? SW'(sq) : '0;
    end else if (xfer_out) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      sq_d  = sq_sum[SW] ? '1 : sq_sum[SW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      cy_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sm_q   <= '0;
      k_q    <= '0;
      ty_q   <= '0;
      ov_q   <= 1'b0;
      osum_q <= '0;
      oerr_q <= '0;
      cnt_q  <= '0;
      sq_q   <= '0;
    end else begin
      if (en) begin
        vld_q <= vld_d;
        cy_q  <= cy_d;
        a_q   <= a_d;
        b_q   <= b_d;
        sm_q  <= sm_d;
        k_q   <= k_d;
        ty_q  <= ty_d;
        ov_q  <= vld_q[LAST];
        if (vld_q[LAST]) begin
          osum_q <= osum_d;
          oerr_q <= oerr_d;
        end
      end
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end

endmodule

// File: tb/tb_approx_rc_adder_pipe.sv
// Directed and randomized checks of the approximate adder pipeline against an
// arithmetic reference model with an in-order scoreboard and statistics model.
module tb_approx_rc_adder_pipe;
  import approx_adder_pkg::*;

  localparam longint SQMAX  = (64'sd1 <<< 52) - 1;
  localparam longint CNTMAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stat_clr = 1'b0;
  logic [15:0] stat_cnt;
  logic [51:0] stat_sqerr;

  approx_rc_adder_pipe_if #(.WIDTH(16), .APPROX_MAX(8)) bus ();

  approx_rc_adder_pipe #(.WIDTH(16), .SEG_W(4), .APPROX_MAX(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt),
    .stat_sqerr(stat_sqerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint s;
    longint e;
  } exp_t;

  exp_t               q[$];
  int                 n_cmp = 0;
  int                 n_bad = 0;
  int                 n_in = 0;
  int                 n_out = 0;
  int                 lat;
  int                 base;
  longint             cnt_m = 0;
  longint             sq_m = 0;
  logic signed [63:0] last_sum, last_err;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Approximate sum from arithmetic on the high part plus a closed-form low part.
  function automatic exp_t model(input longint a, input longint b, input int unsigned k,
                                 input int unsigned t);
    longint hi, ap, lo, c;
    exp_t   r;
    if (k > 8) k = 8;
    hi = (a >> k) + (b >> k);
    if (k == 0 || t == 3) ap = a + b;
    else begin
      case (t)
        0: ap = (hi + 1) << k;
        1: ap = hi << k;
        default: begin
          lo = (a | b) & ((64'sd1 <<< k) - 1);
          c  = ((a & b) >> (k - 1)) & 1;
          ap = ((hi + c) << k) | lo;
        end
      endcase
    end
    r.s = ap;
    r.e = (a + b) - ap;
    return r;
  endfunction

  task automatic step();
    exp_t   ex;
    bit     xo, xi;
    longint e2;
    #1;
    chk("stat_cnt", stat_cnt, cnt_m);
    chk("stat_sqerr", stat_sqerr, sq_m);
    xo = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
    xi = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
    e2 = 0;
    if (xo) begin
      chk("output_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        ex = q.pop_front();
        chk("out_sum", bus.out_sum, ex.s);
        chk("out_err", bus.out_err, ex.e);
        e2 = ex.e * ex.e;
      end
      last_sum = bus.out_sum;
      last_err = bus.out_err;
      n_out++;
    end
    if (xi) begin
      q.push_back(model(longint'(bus.in_a), longint'(bus.in_b), bus.in_k, bus.in_type));
      n_in++;
    end
    if (stat_clr) begin
      cnt_m = xo ? 1 : 0;
      sq_m  = xo ? e2 : 0;
    end else if (xo) begin
      cnt_m = (cnt_m == CNTMAX) ? CNTMAX : cnt_m + 1;
      sq_m  = (sq_m + e2 > SQMAX) ? SQMAX : sq_m + e2;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] k,
                      input cell_type_e t);
    int start, guard;
    start = n_in;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_k     = k;
    bus.in_type  = t;
    while (n_in == start && guard < 50) begin
      step();
      guard++;
    end
    chk("send_accepted", n_in - start, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int target, guard;
    target = n_out + n;
    guard  = 0;
    while (n_out < target && guard < 100) begin
      step();
      guard++;
    end
    chk("drain_outputs", n_out, target);
  endtask

  task automatic lat_check();
    lat = 0;
    #1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_k      = '0;
    bus.in_type   = '0;
    bus.out_ready = 1'b1;

    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_stat_cnt", stat_cnt, 0);
    chk("rst_stat_sqerr", stat_sqerr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(16'h1234, 16'h0001, 4'd8, CT_CONST);
    lat_check();
    step();
    chk("const_sum", last_sum, 64'sh1300);
    chk("const_err", last_err, -203);

    send(16'h00FF, 16'h00FF, 4'd8, CT_TRUNC);
    drain(1);
    chk("trunc_sum", last_sum, 0);
    chk("trunc_err", last_err, 510);
    send(16'h000F, 16'h0003, 4'd4, CT_OR);
    drain(1);
    chk("or_sum", last_sum, 15);
    chk("or_err", last_err, 3);

    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    base = n_out;
    send(16'h000F, 16'h0003, 4'd4, CT_OR);
    send(16'h1234, 16'h0001, 4'd8, CT_CONST);
    send(16'h00FF, 16'h00FF, 4'd8, CT_TRUNC);
    drain(2);
    #1;
    chk("stats_two_cnt", stat_cnt, 2);
    chk("stats_two_sqerr", stat_sqerr, 41218);
    chk("third_pending", bus.out_valid, 1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("third_taken", n_out, base + 3);
    #1;
    chk("clr_xfer_cnt", stat_cnt, 1);
    chk("clr_xfer_sqerr", stat_sqerr, 260100);

    send(16'hFFFF, 16'hFFFF, 4'd15, CT_EXACT);
    drain(1);
    chk("exact_sum", last_sum, 64'sh1FFFE);
    chk("exact_err", last_err, 0);
    send(16'hFFFF, 16'hFFFF, 4'd0, CT_CONST);
    drain(1);
    chk("k0_sum", last_sum, 64'sh1FFFE);
    chk("k0_err", last_err, 0);

    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_a      = 16'($urandom);
      bus.in_b      = 16'($urandom);
      bus.in_k      = 4'($urandom_range(0, 15));
      bus.in_type   = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      stat_clr      = ($urandom_range(0, 19) == 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    stat_clr      = 1'b0;
    for (int g = 0; g < 50 && q.size() > 0; g++) step();
    chk("drain_empty", q.size(), 0);
    chk("no_loss", n_out, n_in);

    bus.out_ready = 1'b0;
    send(16'($urandom), 16'($urandom), 4'd8, CT_CONST);
    send(16'($urandom), 16'($urandom), 4'd3, CT_OR);
    send(16'($urandom), 16'($urandom), 4'd5, CT_TRUNC);
    repeat (3) step();
    #1;
    chk("pre_reset_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_out_sum", bus.out_sum, 0);
    chk("mid_rst_out_err", bus.out_err, 0);
    chk("mid_rst_stat_cnt", stat_cnt, 0);
    chk("mid_rst_stat_sqerr", stat_sqerr, 0);
    q.delete();
    cnt_m = 0;
    sq_m  = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    send(16'h00FF, 16'h00FF, 4'd8, CT_TRUNC);
    lat_check();
    step();
    chk("post_rst_sum", last_sum, 0);
    chk("post_rst_err", last_err, 510);
    repeat (6) step();
    chk("post_rst_count", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
